vedic_multiplier_pipelined: RTL and testbench

Parametrised, pipelined successor to the team's combinational 8x8 Vedic multiplier. Computes a WIDTH x WIDTH product with a per-transaction unsigned/signed mode. Uses the four-quarter Vedic decomposition (Al*Bl, Al*Bh, Ah*Bl, Ah*Bh), split across three register stages. Sits in the convolution datapath between the coefficient/sample fetch and the accumulator, with valid/ready handshaking and full backpressure.

---
 rtl/vedic_pkg.sv | 24 ++
 rtl/vedic_mult_half.sv | 50 +++++
 rtl/vedic_multiplier_pipelined.sv | 143 ++++++++++++++
 tb/tb_vedic_multiplier_pipelined.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants and helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int LATENCY = 3;
    localparam int MAX_W   = 32;

    // Magnitude of a width-bit operand held right-aligned in a MAX_W-bit vector.
    function automatic logic [MAX_W-1:0] vedic_abs(
        input logic [MAX_W-1:0] value,
        input int unsigned      width,
        input logic             is_signed
    );
        logic [MAX_W-1:0] mask;
        logic             sign_bit;
        mask     = (width >= MAX_W) ? {MAX_W{1'b1}} : ((32'd1 << width) - 32'd1);
        sign_bit = |(value & (32'd1 << (width - 32'd1)));
        if (is_signed && sign_bit) begin
            return (~value + 32'd1) & mask;
        end else begin
            return value & mask;
        end
    endfunction

endpackage

// File: rtl/vedic_mult_half.sv
// Combinational unsigned WA x WB Vedic multiplier, recursively split into
// quarter products down to 2x2 cells (odd widths bottom out in AND rows).
module vedic_mult_half #(
    parameter int WA = 4,
    parameter int WB = WA
) (
    input  logic [WA-1:0]    a,
    input  logic [WB-1:0]    b,
    output logic [WA+WB-1:0] p
);

    localparam int PW = WA + WB;

    generate
        if (WA == 1) begin : g_row_a
            assign p = {1'b0, b & {WB{a[0]}}};
        end else if (WB == 1) begin : g_row_b
            assign p = {1'b0, a & {WA{b[0]}}};
        end else if (WA == 2 && WB == 2) begin : g_cell
            logic c1;
            assign c1 = a[1] & b[0] & a[0] & b[1];
            assign p  = {a[1] & b[1] & c1,
                         (a[1] & b[1]) ^ c1,
                         (a[1] & b[0]) ^ (a[0] & b[1]),
                         a[0] & b[0]};
        end else begin : g_split
            localparam int LA = WA / 2;
            localparam int HA = WA - LA;
            localparam int LB = WB / 2;
            localparam int HB = WB - LB;

            logic [LA+LB-1:0] p_ll;
            logic [LA+HB-1:0] p_lh;
            logic [HA+LB-1:0] p_hl;
            logic [HA+HB-1:0] p_hh;

            vedic_mult_half #(.WA(LA), .WB(LB)) u_ll (.a(a[LA-1:0]),  .b(b[LB-1:0]),  .p(p_ll));
            vedic_mult_half #(.WA(LA), .WB(HB)) u_lh (.a(a[LA-1:0]),  .b(b[WB-1:LB]), .p(p_lh));
            vedic_mult_half #(.WA(HA), .WB(LB)) u_hl (.a(a[WA-1:LA]), .b(b[LB-1:0]),  .p(p_hl));
            vedic_mult_half #(.WA(HA), .WB(HB)) u_hh (.a(a[WA-1:LA]), .b(b[WB-1:LB]), .p(p_hh));

            // The true product always fits PW bits, so modular addition is exact.
            assign p = PW'(p_ll)
                     + (PW'(p_lh) << LB)
                     + (PW'(p_hl) << LA)
                     + (PW'(p_hh) << (LA + LB));
        end
    endgenerate

endmodule

// File: rtl/vedic_multiplier_pipelined.sv
// Three-stage signed/unsigned WIDTH x WIDTH Vedic multiplier with valid/ready
// handshaking; a held output product freezes the whole pipeline.
module vedic_multiplier_pipelined
    import vedic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int HW = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    typedef struct packed {
        logic [WIDTH-1:0] m1;
        logic [WIDTH-1:0] m2;
        logic [WIDTH-1:0] m3;
        logic [WIDTH-1:0] m4;
        logic             neg;
        logic [TAG_W-1:0] tag;
    } vedic_pp_t;

    logic             advance_s;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_neg_q, s1_neg_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s2_valid_q, s2_valid_d;
    vedic_pp_t        s2_pp_q, s2_pp_d;
    logic             out_valid_q, out_valid_d;
    logic [PW-1:0]    out_p_q, out_p_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [WIDTH-1:0] m1_s, m2_s, m3_s, m4_s;
    logic [WIDTH:0]   mid_s;
    logic [PW-1:0]    mag_s;

    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_tag   = out_tag_q;

    vedic_mult_half #(.WA(HW), .WB(HW)) u_m1 (.a(s1_a_q[HW-1:0]),     .b(s1_b_q[HW-1:0]),     .p(m1_s));
    vedic_mult_half #(.WA(HW), .WB(HW)) u_m2 (.a(s1_a_q[HW-1:0]),     .b(s1_b_q[WIDTH-1:HW]), .p(m2_s));
    vedic_mult_half #(.WA(HW), .WB(HW)) u_m3 (.a(s1_a_q[WIDTH-1:HW]), .b(s1_b_q[HW-1:0]),     .p(m3_s));
    vedic_mult_half #(.WA(HW), .WB(HW)) u_m4 (.a(s1_a_q[WIDTH-1:HW]), .b(s1_b_q[WIDTH-1:HW]), .p(m4_s));

    // S1: operand magnitudes and result sign.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_neg_d   = s1_neg_q;
        s1_tag_d   = s1_tag_q;
        if (advance_s) begin
            s1_valid_d = in_valid;
            s1_a_d     = WIDTH'(vedic_abs(MAX_W'(in_a), WIDTH, in_signed));
            s1_b_d     = WIDTH'(vedic_abs(MAX_W'(in_b), WIDTH, in_signed));
            s1_neg_d   = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            s1_tag_d   = in_tag;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // S2: capture the four quarter products.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_pp_d    = s2_pp_q;
        if (advance_s) begin
            s2_valid_d     = s1_valid_q;
            s2_pp_d.m1     = m1_s;
            s2_pp_d.m2     = m2_s;
            s2_pp_d.m3     = m3_s;
            s2_pp_d.m4     = m4_s;
            s2_pp_d.neg    = s1_neg_q;
            s2_pp_d.tag    = s1_tag_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // S3: recombine and apply sign; a zero magnitude negates to zero.
    always_comb begin
        mid_s       = {1'b0, s2_pp_q.m2} + {1'b0, s2_pp_q.m3};
        mag_s       = PW'(s2_pp_q.m1) + (PW'(mid_s) << HW) + (PW'(s2_pp_q.m4) << WIDTH);
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_tag_d   = out_tag_q;
        if (advance_s) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                out_p_d   = s2_pp_q.neg ? (~mag_s + PW'(1'b1)) : mag_s;
                out_tag_d = s2_pp_q.tag;
            end else begin
                out_p_d   = {PW{1'b0}};
                out_tag_d = {TAG_W{1'b0}};
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= {WIDTH{1'b0}};
            s1_b_q      <= {WIDTH{1'b0}};
            s1_neg_q    <= 1'b0;
            s1_tag_q    <= {TAG_W{1'b0}};
            s2_valid_q  <= 1'b0;
            s2_pp_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= {PW{1'b0}};
            out_tag_q   <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_neg_q    <= s1_neg_d;
            s1_tag_q    <= s1_tag_d;
            s2_valid_q  <= s2_valid_d;
            s2_pp_q     <= s2_pp_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_tag_q   <= out_tag_d;
        end
    end

endmodule

// File: tb/tb_vedic_multiplier_pipelined.sv
// Directed and randomised checks of the pipelined Vedic multiplier (8- and 16-bit).
module tb_vedic_multiplier_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_p;

    logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
    logic [15:0] in_a16, in_b16;
    logic [3:0]  in_tag16, out_tag16;
    logic [31:0] out_p16;

    vedic_multiplier_pipelined #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
    );

    vedic_multiplier_pipelined #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_b(in_b16),
        .in_signed(in_signed16), .in_tag(in_tag16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_p(out_p16), .out_tag(out_tag16)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int stall_cnt    = 0;
    bit mon_en       = 1'b0;
    bit rand_run     = 1'b0;

    logic [15:0] exp_p_q[$];
    logic [3:0]  exp_tag_q[$];
    int          pop_cyc_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        longint pa, pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return 16'(pa * pb);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every product leaving dut8 must match the oldest expectation.
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            if (exp_p_q.size() == 0) begin
                check_eq("extra_beat", 64'(out_valid), 64'd0);
            end else begin
                check_eq("prod", 64'(out_p), 64'(exp_p_q.pop_front()));
                check_eq("tag", 64'(out_tag), 64'(exp_tag_q.pop_front()));
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [3:0] t, input logic [15:0] ep);
        int waits = 0;
        bit acc   = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = t;
        while (!acc && waits < 50) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
            waits++;
        end
        if (!acc) begin
            check_eq("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            exp_p_q.push_back(ep);
            exp_tag_q.push_back(t);
        end
    endtask

    task automatic latency8(input logic [7:0] a, input logic [7:0] b, input logic s,
                            input logic [3:0] t, input logic [15:0] ep);
        int n = 1;
        bit seen = 1'b0;
        send(a, b, s, t, ep);
        in_valid = 1'b0;
        while (!seen && n < 10) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check_eq("lat_p", 64'(out_p), 64'(ep));
                check_eq("lat_tag", 64'(out_tag), 64'(t));
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check_eq("latency", 64'(n), 64'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (exp_p_q.size() != 0 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_empty", 64'(exp_p_q.size()), 64'd0);
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] ep, input string tag);
        int n = 0;
        in_valid16  = 1'b1;
        in_a16      = a;
        in_b16      = b;
        in_signed16 = s;
        in_tag16    = 4'hA;
        @(negedge clk);
        check_eq("rdy16", 64'(in_ready16), 64'd1);
        @(posedge clk);
        #1;
        in_valid16 = 1'b0;
        while (!out_valid16 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, 64'(out_p16), 64'(ep));
        check_eq("tag16", 64'(out_tag16), 64'hA);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_cnt;
        logic [7:0] ra, rb;
        logic       rs;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_signed = 1'b0; in_tag = 4'h0;
        out_ready = 1'b1;
        in_valid16 = 1'b0; in_a16 = 16'h0; in_b16 = 16'h0; in_signed16 = 1'b0; in_tag16 = 4'h0;
        out_ready16 = 1'b1;

        // Reset state and ready after release.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(out_valid), 64'd0);
        check_eq("rst_p", 64'(out_p), 64'd0);
        check_eq("rst_tag", 64'(out_tag), 64'd0);
        check_eq("rst_valid16", 64'(out_valid16), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rdy_after_rst", 64'(in_ready), 64'd1);
        mon_en = 1'b1;

        // Unsigned full-scale with latency.
        latency8(8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01);
        drain(20);

        // Signed corner cases back to back.
        pop_cyc_q.delete();
        stall_cnt = 0;
        send(8'h80, 8'h80, 1'b1, 4'd5, 16'h4000);
        send(8'hFF, 8'h7F, 1'b1, 4'd6, 16'hFF81);
        send(8'h00, 8'hFB, 1'b1, 4'd7, 16'h0000);
        in_valid = 1'b0;
        drain(20);
        check_eq("b2b_stalls", 64'(stall_cnt), 64'd0);
        check_eq("b2b_count", 64'(pop_cyc_q.size()), 64'd3);
        if (pop_cyc_q.size() == 3) begin
            check_eq("b2b_gap1", 64'(pop_cyc_q[1] - pop_cyc_q[0]), 64'd1);
            check_eq("b2b_gap2", 64'(pop_cyc_q[2] - pop_cyc_q[1]), 64'd1);
        end

        // Backpressure: hold out_ready low while four beats stream in.
        out_ready = 1'b0;
        fork
            begin
                send(8'hFF, 8'hFF, 1'b0, 4'd1, 16'hFE01);
                send(8'h03, 8'h05, 1'b0, 4'd2, 16'h000F);
                send(8'h10, 8'h10, 1'b0, 4'd3, 16'h0100);
                send(8'hC8, 8'h02, 1'b0, 4'd4, 16'h0190);
                in_valid = 1'b0;
            end
            begin
                for (int k = 1; k <= 5; k++) begin
                    @(negedge clk);
                    if (k >= 4) begin
                        check_eq("stall_rdy", 64'(in_ready), 64'd0);
                        check_eq("stall_valid", 64'(out_valid), 64'd1);
                        check_eq("stall_p", 64'(out_p), 64'hFE01);
                        check_eq("stall_tag", 64'(out_tag), 64'd1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(30);

        // 16-bit instance.
        run16(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "w16_signed");
        run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w16_unsigned");
        run16(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "w16_neg1sq");

        // Reset with three beats in flight.
        mon_en = 1'b0;
        send(8'h12, 8'h34, 1'b0, 4'd8, 16'h03A8);
        send(8'h05, 8'h06, 1'b0, 4'd9, 16'h001E);
        send(8'h07, 8'h09, 1'b0, 4'd10, 16'h003F);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 64'(out_valid), 64'd0);
        check_eq("midrst_p", 64'(out_p), 64'd0);
        exp_p_q.delete();
        exp_tag_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        hi_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        check_eq("no_stale", 64'(hi_cnt), 64'd0);
        @(posedge clk);
        #1;
        latency8(8'h0B, 8'h0D, 1'b0, 4'd9, 16'h008F);
        drain(20);

        // Random mix with random backpressure.
        rand_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rs = 1'($urandom);
                    send(ra, rb, rs, 4'(i), model8(ra, rb, rs));
                end
                in_valid = 1'b0;
                rand_run = 1'b0;
            end
            begin
                while (rand_run) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain(200);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
